// File: rtl/cam_pkg.sv
// Shared types and RGB565 helpers for the DVP capture block.
package cam_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_FRAME = 2'd2
  } cam_state_e;

  localparam int R5_HI = 15;
  localparam int R5_LO = 11;
  localparam int G6_HI = 10;
  localparam int G6_LO = 5;
  localparam int B5_HI = 4;
  localparam int B5_LO = 0;

  // Replicate the top bits into the new LSBs so full-scale maps to 0xFF.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = p[R5_HI:R5_LO];
    g6 = p[G6_HI:G6_LO];
    b5 = p[B5_HI:B5_LO];
    return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  endfunction

endpackage

// File: rtl/cam_in_sync.sv
// Brings the asynchronous DVP pins into the system clock domain and
// produces registered edge strobes with cam_d aligned to pclk_rise.
module cam_in_sync (
  input  logic       CLOCK_50_B5B,
  input  logic       RESET,
  input  logic       cam_pclk,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_d,
  output logic       pclk_rise,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href_fall,
  output logic       href_lvl,
  output logic [7:0] d_q
);

  // [1:0] is the synchronizer, [2] holds the previous synchronized value.
  logic [2:0] pclk_sr;
  logic [2:0] vsync_sr;
  logic [2:0] href_sr;
  logic [7:0] d1;
  logic [7:0] d2;

  always_ff @(posedge CLOCK_50_B5B) begin
    if (!RESET) begin
      pclk_sr    <= '0;
      vsync_sr   <= '0;
      href_sr    <= '0;
      d1         <= '0;
      d2         <= '0;
      d_q        <= '0;
      pclk_rise  <= 1'b0;
      vsync_rise <= 1'b0;
      vsync_fall <= 1'b0;
      href_fall  <= 1'b0;
      href_lvl   <= 1'b0;
    end else begin
      pclk_sr    <= {pclk_sr[1:0], cam_pclk};
      vsync_sr   <= {vsync_sr[1:0], cam_vsync};
      href_sr    <= {href_sr[1:0], cam_href};
      d1         <= cam_d;
      d2         <= d1;
      d_q        <= d2;
      pclk_rise  <= pclk_sr[1] & ~pclk_sr[2];
      vsync_rise <= vsync_sr[1] & ~vsync_sr[2];
      vsync_fall <= ~vsync_sr[1] & vsync_sr[2];
      href_fall  <= ~href_sr[1] & href_sr[2];
      href_lvl   <= href_sr[1];
    end
  end

endmodule

// File: rtl/cam_dvp_capture.sv
// DVP RGB565 capture into frame-buffer write beats (RGB888), with
// frame arming on vsync fall and sticky line/frame geometry errors.
module cam_dvp_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              CLOCK_50_B5B,
  input  logic              RESET,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  input  logic              enable,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic              line_err,
  output logic              frame_err,
  output logic [7:0]        frame_count,
  output cam_state_e        fsm_state
);

  localparam int XW = $clog2(H_ACTIVE + 2);
  localparam int YW = $clog2(V_ACTIVE + 2);
  localparam logic [XW-1:0]     X_MAX     = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     Y_MAX     = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  logic       pclk_rise, vsync_rise, vsync_fall, href_fall, href_lvl;
  logic [7:0] d_q;

  cam_in_sync u_sync (
    .CLOCK_50_B5B (CLOCK_50_B5B),
    .RESET        (RESET),
    .cam_pclk     (cam_pclk),
    .cam_vsync    (cam_vsync),
    .cam_href     (cam_href),
    .cam_d        (cam_d),
    .pclk_rise    (pclk_rise),
    .vsync_rise   (vsync_rise),
    .vsync_fall   (vsync_fall),
    .href_fall    (href_fall),
    .href_lvl     (href_lvl),
    .d_q          (d_q)
  );

  cam_state_e        state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              phase;
  logic [7:0]        hi_byte;
  logic [ADDR_W-1:0] line_base;
  logic [XW-1:0]     x_inc;
  logic [YW-1:0]     y_after_line;

  assign fsm_state = state;

  // Counters saturate so an overlong line or frame cannot wrap back in range.
  always_comb begin
    x_inc = (x == '1) ? x : x + XW'(1);
    y_after_line = y;
    if (href_fall && x != '0 && y != '1) y_after_line = y + YW'(1);
  end

  always_ff @(posedge CLOCK_50_B5B) begin
    if (!RESET) begin
      state       <= S_IDLE;
      x           <= '0;
      y           <= '0;
      phase       <= 1'b0;
      hi_byte     <= '0;
      line_base   <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      wr_en       <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            state <= S_ARM;
            busy  <= 1'b1;
          end
        end
        S_ARM: begin
          if (vsync_fall) begin
            state     <= S_FRAME;
            x         <= '0;
            y         <= '0;
            phase     <= 1'b0;
            line_base <= '0;
          end
        end
        S_FRAME: begin
          if (pclk_rise && href_lvl) begin
            if (!phase) begin
              hi_byte <= d_q;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              x     <= x_inc;
              if (x < X_MAX && y < Y_MAX) begin
                wr_en       <= 1'b1;
                wr_addr     <= line_base + ADDR_W'(x);
                wr_data     <= rgb565_to_888({hi_byte, d_q});
                frame_start <= (x == '0) && (y == '0);
              end
            end
          end
          // Line end is applied before frame end so a coincident vsync sees the final y.
          if (href_fall) begin
            if (x != X_MAX || phase) line_err <= 1'b1;
            x     <= '0;
            phase <= 1'b0;
            y     <= y_after_line;
            if (x != '0 && y < Y_MAX) line_base <= line_base + LINE_STEP;
          end
          if (vsync_rise) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
            if (y_after_line != Y_MAX) frame_err <= 1'b1;
            if (enable) begin
              state <= S_ARM;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
